// File: rtl/led_snake_pkg.sv
// Shared types and constants for the LED stripe frame sequencer.
// Channel scaling helper is used only with LED_GLOBAL_BRIGHTNESS_EN.
package led_snake_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_LOAD     = 3'd2,
        ST_SCALE    = 3'd3,
        ST_SHIFT    = 3'd4,
        ST_DONE     = 3'd5,
        ST_WAIT_RST = 3'd6
    } state_e;

    localparam int BITS_PER_LED = 24;
    localparam int G_MSB        = 23;
    localparam int R_MSB        = 15;
    localparam int B_MSB        = 7;

    // Unsigned 16-bit product, keep the upper byte (truncating divide by 256).
    function automatic logic [7:0] scale_ch(input logic [7:0] ch,
                                            input logic [7:0] br);
        logic [15:0] prod;
        prod = 16'(ch) * 16'(br);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/led_pixel_scaler.sv
// Combinational global-brightness scaling of one GRB pixel word.
// Instantiated only when LED_GLOBAL_BRIGHTNESS_EN is defined.
module led_pixel_scaler
    import led_snake_pkg::*;
(
    input  logic [23:0] pix_i,
    input  logic [7:0]  bright_i,
    output logic [23:0] pix_o
);

    assign pix_o = {scale_ch(pix_i[G_MSB -: 8], bright_i),
                    scale_ch(pix_i[R_MSB -: 8], bright_i),
                    scale_ch(pix_i[B_MSB -: 8], bright_i)};

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame sequencer: fetches GRB pixels and serialises them MSB-first.
// Optional global brightness scaling via LED_GLOBAL_BRIGHTNESS_EN.
module led_frame_sequencer
    import led_snake_pkg::*;
#(
    parameter int NUM_LEDS = 64,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              frame_start,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              pix_rd_en,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [23:0]       pix_data,
    input  logic              new_bit_rqst,
    output logic              bit_to_transmit,
    output logic              all_bits_shifted,
    input  logic              new_frame_rqst,
    output logic              bit_underrun
`ifdef LED_GLOBAL_BRIGHTNESS_EN
    ,
    input  logic [7:0]        brightness
`endif
);

    localparam logic [ADDR_W-1:0] LED_LAST = ADDR_W'(NUM_LEDS - 1);
    localparam logic [4:0]        BIT_LAST = 5'(BITS_PER_LED - 1);

    state_e            state_q, state_d;
    logic [23:0]       shift_q, shift_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] led_cnt_q, led_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              underrun_q, underrun_d;

`ifdef LED_GLOBAL_BRIGHTNESS_EN
    logic [7:0]  bright_q, bright_d;
    logic [23:0] pix_scaled;

    led_pixel_scaler u_scaler (
        .pix_i    (shift_q),
        .bright_i (bright_q),
        .pix_o    (pix_scaled)
    );
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            led_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef LED_GLOBAL_BRIGHTNESS_EN
            bright_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            led_cnt_q  <= led_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
`ifdef LED_GLOBAL_BRIGHTNESS_EN
            bright_q   <= bright_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        led_cnt_d  = led_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;
`ifdef LED_GLOBAL_BRIGHTNESS_EN
        bright_d   = bright_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d    = ST_FETCH;
                    busy_d     = 1'b1;
                    led_cnt_d  = '0;
                    underrun_d = 1'b0;
`ifdef LED_GLOBAL_BRIGHTNESS_EN
                    bright_d   = brightness;
`endif
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
                if (new_bit_rqst) underrun_d = 1'b1;
            end
            ST_LOAD: begin
                shift_d   = pix_data;
                bit_cnt_d = '0;
`ifdef LED_GLOBAL_BRIGHTNESS_EN
                state_d   = ST_SCALE;
`else
                state_d   = ST_SHIFT;
`endif
                if (new_bit_rqst) underrun_d = 1'b1;
            end
            ST_SCALE: begin
`ifdef LED_GLOBAL_BRIGHTNESS_EN
                shift_d = pix_scaled;
                state_d = ST_SHIFT;
                if (new_bit_rqst) underrun_d = 1'b1;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_SHIFT: begin
                if (new_bit_rqst) begin
                    if (bit_cnt_q != BIT_LAST) begin
                        shift_d   = {shift_q[22:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end else if (led_cnt_q != LED_LAST) begin
                        led_cnt_d = led_cnt_q + ADDR_W'(1);
                        state_d   = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_WAIT_RST;
                if (new_bit_rqst) underrun_d = 1'b1;
            end
            ST_WAIT_RST: begin
                if (new_bit_rqst) underrun_d = 1'b1;
                if (new_frame_rqst) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign frame_busy       = busy_q;
    assign frame_done       = done_q;
    assign pix_rd_en        = (state_q == ST_FETCH);
    assign pix_addr         = led_cnt_q;
    assign bit_to_transmit  = (state_q == ST_SHIFT) & shift_q[23];
    assign all_bits_shifted = (state_q == ST_DONE);
    assign bit_underrun     = underrun_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed self-checking bench for led_frame_sequencer (NUM_LEDS=2).
// Brightness scenarios are built only with LED_GLOBAL_BRIGHTNESS_EN.
module tb_led_frame_sequencer;

    localparam int NL = 2;
    localparam int AW = 6;
    localparam logic [47:0] EXP_BITS = {24'hFF0000, 24'h00000F};

    logic          clk;
    logic          rstn;
    logic          frame_start;
    logic          frame_busy;
    logic          frame_done;
    logic          pix_rd_en;
    logic [AW-1:0] pix_addr;
    logic [23:0]   pix_data;
    logic          new_bit_rqst;
    logic          bit_to_transmit;
    logic          all_bits_shifted;
    logic          new_frame_rqst;
    logic          bit_underrun;
`ifdef LED_GLOBAL_BRIGHTNESS_EN
    logic [7:0]    brightness;
`endif

    logic [23:0] mem [0:63];
    logic [AW-1:0] rd_addr [0:7];
    int n_cmp, n_err;
    int cyc, last_req;
    int rd_n, asb_n, asb_cyc, fd_n;

    led_frame_sequencer #(.NUM_LEDS(NL), .ADDR_W(AW)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .frame_start      (frame_start),
        .frame_busy       (frame_busy),
        .frame_done       (frame_done),
        .pix_rd_en        (pix_rd_en),
        .pix_addr         (pix_addr),
        .pix_data         (pix_data),
        .new_bit_rqst     (new_bit_rqst),
        .bit_to_transmit  (bit_to_transmit),
        .all_bits_shifted (all_bits_shifted),
        .new_frame_rqst   (new_frame_rqst),
        .bit_underrun     (bit_underrun)
`ifdef LED_GLOBAL_BRIGHTNESS_EN
        ,
        .brightness       (brightness)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pix_rd_en) pix_data <= mem[pix_addr];
    end

    always @(negedge clk) begin
        if (pix_rd_en) begin
            if (rd_n < 8) rd_addr[rd_n] = pix_addr;
            rd_n = rd_n + 1;
        end
        if (all_bits_shifted) begin
            asb_n   = asb_n + 1;
            asb_cyc = cyc;
        end
        if (frame_done) fd_n = fd_n + 1;
    end

    task automatic clear_counts;
        rd_n  = 0;
        asb_n = 0;
        fd_n  = 0;
    endtask

    task automatic reset_pulse;
        @(negedge clk) rstn = 1'b0;
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
    endtask

    // Transmitter model: 120-cycle bit period, 500-cycle reset time.
    task automatic run_frame(input bit rq_fetch, input bit st_shift,
                             input bit st_wait, output logic [47:0] bits);
        bits = '0;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        n_cmp++;
        if (frame_busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start got %b want 1", frame_busy);
        end
        if (rq_fetch) begin
            n_cmp++;
            if (pix_rd_en !== 1'b1) begin
                n_err++;
                $display("FAIL fetch_state got rd_en %b want 1", pix_rd_en);
            end
            new_bit_rqst = 1'b1;
            @(negedge clk) new_bit_rqst = 1'b0;
            n_cmp++;
            if (bit_underrun !== 1'b1) begin
                n_err++;
                $display("FAIL underrun_set got %b want 1", bit_underrun);
            end
        end
        for (int i = 0; i < 48; i++) begin
            repeat (119) @(negedge clk);
            if (st_shift && i == 5) frame_start = 1'b1;
            new_bit_rqst = 1'b1;
            bits[47-i]   = bit_to_transmit;
            last_req     = cyc;
            @(negedge clk);
            new_bit_rqst = 1'b0;
            frame_start  = 1'b0;
        end
        n_cmp++;
        if (all_bits_shifted !== 1'b1) begin
            n_err++;
            $display("FAIL asb_after_last got %b want 1", all_bits_shifted);
        end
        for (int k = 0; k < 499; k++) begin
            @(negedge clk);
            frame_start = st_wait && (k == 100);
        end
        n_cmp++;
        if (frame_busy !== 1'b1 || all_bits_shifted !== 1'b0) begin
            n_err++;
            $display("FAIL wait_rst_hold got busy %b asb %b want 1 0",
                     frame_busy, all_bits_shifted);
        end
        new_frame_rqst = 1'b1;
        frame_start    = st_wait;
        @(negedge clk);
        new_frame_rqst = 1'b0;
        frame_start    = 1'b0;
        n_cmp++;
        if (frame_done !== 1'b1 || frame_busy !== 1'b0) begin
            n_err++;
            $display("FAIL frame_done_pulse got done %b busy %b want 1 0",
                     frame_done, frame_busy);
        end
        @(negedge clk);
        n_cmp++;
        if (frame_done !== 1'b0 || frame_busy !== 1'b0) begin
            n_err++;
            $display("FAIL frame_done_end got done %b busy %b want 0 0",
                     frame_done, frame_busy);
        end
    endtask

    task automatic test_reset;
        logic [11:0] outs;
        #3 rstn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            frame_start    = 1'($urandom);
            new_bit_rqst   = 1'($urandom);
            new_frame_rqst = 1'($urandom);
            #1;
            outs = {frame_busy, frame_done, pix_rd_en, pix_addr,
                    bit_to_transmit, all_bits_shifted, bit_underrun};
            n_cmp++;
            if (outs !== 12'h000) begin
                n_err++;
                $display("FAIL reset_outputs got %h want 000", outs);
            end
        end
        frame_start    = 1'b0;
        new_bit_rqst   = 1'b0;
        new_frame_rqst = 1'b0;
        @(negedge clk) rstn = 1'b1;
        @(negedge clk) new_bit_rqst = 1'b1;
        @(negedge clk) new_bit_rqst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bit_underrun !== 1'b0 || frame_busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ignores_rqst got und %b busy %b want 0 0",
                     bit_underrun, frame_busy);
        end
    endtask

    task automatic test_frame;
        logic [47:0] bits;
        clear_counts();
        run_frame(1'b0, 1'b0, 1'b0, bits);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bits !== EXP_BITS) begin
            n_err++;
            $display("FAIL frame_bits got %h want %h", bits, EXP_BITS);
        end
        n_cmp++;
        if (rd_n != 2 || rd_addr[0] !== 6'd0 || rd_addr[1] !== 6'd1) begin
            n_err++;
            $display("FAIL fetch_seq got n %0d a0 %0d a1 %0d want 2 0 1",
                     rd_n, rd_addr[0], rd_addr[1]);
        end
        n_cmp++;
        if (asb_n != 1 || asb_cyc != last_req + 1) begin
            n_err++;
            $display("FAIL asb_timing got n %0d cyc %0d want 1 %0d",
                     asb_n, asb_cyc, last_req + 1);
        end
        n_cmp++;
        if (fd_n != 1) begin
            n_err++;
            $display("FAIL frame_done_count got %0d want 1", fd_n);
        end
    endtask

    task automatic test_ignore_start;
        logic [47:0] bits;
        clear_counts();
        run_frame(1'b0, 1'b1, 1'b1, bits);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (bits !== EXP_BITS) begin
            n_err++;
            $display("FAIL ign_bits got %h want %h", bits, EXP_BITS);
        end
        n_cmp++;
        if (rd_n != 2 || asb_n != 1 || frame_busy !== 1'b0) begin
            n_err++;
            $display("FAIL ign_not_queued got rd %0d asb %0d busy %b want 2 1 0",
                     rd_n, asb_n, frame_busy);
        end
        run_frame(1'b0, 1'b0, 1'b0, bits);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bits !== EXP_BITS || rd_n != 4 || asb_n != 2) begin
            n_err++;
            $display("FAIL second_frame got %h rd %0d asb %0d want %h 4 2",
                     bits, rd_n, asb_n, EXP_BITS);
        end
    endtask

    task automatic test_underrun;
        logic [47:0] bits;
        run_frame(1'b1, 1'b0, 1'b0, bits);
        n_cmp++;
        if (bit_underrun !== 1'b1) begin
            n_err++;
            $display("FAIL underrun_held got %b want 1", bit_underrun);
        end
        n_cmp++;
        if (bits !== EXP_BITS) begin
            n_err++;
            $display("FAIL underrun_bits got %h want %h", bits, EXP_BITS);
        end
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        n_cmp++;
        if (bit_underrun !== 1'b0) begin
            n_err++;
            $display("FAIL underrun_clear got %b want 0", bit_underrun);
        end
        reset_pulse();
    endtask

    task automatic test_mid_reset;
        logic [11:0] outs;
        clear_counts();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        for (int i = 0; i < 34; i++) begin
            repeat (119) @(negedge clk);
            new_bit_rqst = 1'b1;
            @(negedge clk) new_bit_rqst = 1'b0;
        end
        n_cmp++;
        if (pix_addr !== 6'd1 || frame_busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_position got addr %0d busy %b want 1 1",
                     pix_addr, frame_busy);
        end
        rstn = 1'b0;
        #1;
        outs = {frame_busy, frame_done, pix_rd_en, pix_addr,
                bit_to_transmit, all_bits_shifted, bit_underrun};
        n_cmp++;
        if (outs !== 12'h000) begin
            n_err++;
            $display("FAIL mid_reset_outputs got %h want 000", outs);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (600) @(negedge clk);
        n_cmp++;
        if (asb_n != 0 || fd_n != 0 || frame_busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_quiet got asb %0d fd %0d busy %b want 0 0 0",
                     asb_n, fd_n, frame_busy);
        end
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        n_cmp++;
        if (pix_rd_en !== 1'b1 || pix_addr !== 6'd0) begin
            n_err++;
            $display("FAIL restart_addr got rd %b addr %0d want 1 0",
                     pix_rd_en, pix_addr);
        end
        reset_pulse();
    endtask

`ifdef LED_GLOBAL_BRIGHTNESS_EN
    task automatic test_brightness;
        logic [47:0] bits;
        mem[0] = 24'hFFFFFF;
        mem[1] = 24'hFFFFFF;
        brightness = 8'h80;
        run_frame(1'b0, 1'b0, 1'b0, bits);
        n_cmp++;
        if (bits !== {24'h7F7F7F, 24'h7F7F7F}) begin
            n_err++;
            $display("FAIL bright_80 got %h want 7f7f7f7f7f7f", bits);
        end
        brightness = 8'h00;
        run_frame(1'b0, 1'b0, 1'b0, bits);
        n_cmp++;
        if (bits !== 48'h0) begin
            n_err++;
            $display("FAIL bright_00 got %h want 0", bits);
        end
    endtask
`endif

    initial begin
        clk            = 1'b0;
        rstn           = 1'b1;
        frame_start    = 1'b0;
        new_bit_rqst   = 1'b0;
        new_frame_rqst = 1'b0;
        n_cmp          = 0;
        n_err          = 0;
        cyc            = 0;
        last_req       = 0;
        asb_cyc        = 0;
        clear_counts();
        for (int i = 0; i < 64; i++) mem[i] = 24'h0;
        for (int i = 0; i < 8; i++) rd_addr[i] = '0;
        mem[0] = 24'hFF0000;
        mem[1] = 24'h00000F;
`ifdef LED_GLOBAL_BRIGHTNESS_EN
        brightness = 8'hFF;
`endif
        test_reset();
`ifdef LED_GLOBAL_BRIGHTNESS_EN
        test_brightness();
`else
        test_frame();
        test_ignore_start();
        test_underrun();
        test_mid_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
